sub16_serial: RTL and testbench

Nibble-serial 16-bit subtractor with flag generation: the subtract-direction counterpart of the team's 16-bit add datapath. It accepts an operand pair over a valid/ready handshake and computes Z = X − Y four bits per cycle through one borrow-lookahead nibble stage. It returns Z plus Carry/Parity/Overflow/Zero/Sign over a second valid/ready handshake. It sits beside the adder in the ALU where area matters more than single-cycle latency.

---
 rtl/sub16_serial_pkg.sv | 55 +++++
 rtl/sub16_serial_sub4_cla.sv | 35 +++
 rtl/sub16_serial.sv | 158 +++++++++++++++
 tb/tb_sub16_serial.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sub16_serial_pkg.sv
// rtl/sub16_serial_pkg.sv - shared types, constants and flag helper for sub16_serial
//
// Purpose : state encoding, width constants and the flag bundle used by the
//           nibble-serial subtractor, plus the flag computation applied to a
//           finished 16-bit result.
// Ports   : none (package).

package sub16_serial_pkg;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;
    localparam int NNIB  = WIDTH / NIB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic carry;
        logic parity;
        logic overflow;
        logic zero;
        logic sign;
    } flags_t;

    // Flag state matching a cleared Z register.
    localparam flags_t FLAGS_RESET = '{carry: 1'b0, parity: 1'b1, overflow: 1'b0,
                                       zero: 1'b1, sign: 1'b0};

    // x/y are the operands as presented (y not inverted), z the final result,
    // cout the raw carry out of the top nibble. For subtraction the carry flag
    // is the borrow, i.e. the inverted raw carry.
    function automatic flags_t calc_flags(input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y,
                                          input logic [WIDTH-1:0] z,
                                          input logic             cout,
                                          input logic             is_add);
        flags_t f;
        f.carry    = is_add ? cout : ~cout;
        f.parity   = ~^z;
        f.zero     = (z == '0);
        f.sign     = z[WIDTH-1];
        if (is_add) begin
            f.overflow = (x[WIDTH-1] & y[WIDTH-1] & ~z[WIDTH-1]) |
                         (~x[WIDTH-1] & ~y[WIDTH-1] & z[WIDTH-1]);
        end else begin
            f.overflow = (x[WIDTH-1] & ~y[WIDTH-1] & ~z[WIDTH-1]) |
                         (~x[WIDTH-1] & y[WIDTH-1] & z[WIDTH-1]);
        end
        return f;
    endfunction

endpackage

// File: rtl/sub16_serial_sub4_cla.sv
// rtl/sub16_serial_sub4_cla.sv - 4-bit carry-lookahead nibble stage
//
// Purpose : combinational 4-bit adder with lookahead carries; the caller
//           supplies an already-inverted b and cin=1 to subtract.
// Ports   : a[3:0], b[3:0] operands; cin carry in;
//           s[3:0] sum; cout carry out of bit 3.

module sub4_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) |
                    (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) |
                    (w_p[3] & w_p[2] & w_p[1] & w_g[0]) |
                    (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign s    = w_p ^ w_c[3:0];
    assign cout = w_c[4];

endmodule

// File: rtl/sub16_serial.sv
// rtl/sub16_serial.sv - nibble-serial 16-bit subtractor with flags
//
// Purpose : computes Z = X - Y four bits per cycle through one reused
//           lookahead nibble stage and registers Carry/Parity/Overflow/
//           Zero/Sign with the result. Optional macro SUB16_ADDMODE_EN adds
//           the op port (0 = subtract, 1 = add).
// Ports   : clk, rst_n (async active-low);
//           in_valid/in_ready handshake with X, Y (and op) operands;
//           out_valid/out_ready handshake with Z and the five flags.

module sub16_serial
    import sub16_serial_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
`ifdef SUB16_ADDMODE_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             Carry,
    output logic             Parity,
    output logic             Overflow,
    output logic             Zero,
    output logic             Sign
);

    localparam int IDXW = $clog2(NNIB);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NNIB - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    flags_t           r_flags;

    logic             w_accept;
    logic             w_last;
    logic             w_op_in;
    logic             w_op;
    logic [NIB-1:0]   w_a;
    logic [NIB-1:0]   w_b;
    logic [NIB-1:0]   w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_z_final;

`ifdef SUB16_ADDMODE_EN
    logic r_op;
    assign w_op_in = op;
    assign w_op    = r_op;
`else
    assign w_op_in = 1'b0;
    assign w_op    = 1'b0;
`endif

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_nxt = ST_CALC;
            ST_CALC: if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Current nibble of the operands; subtraction feeds ~Y into the adder.
    assign w_a = r_x[{r_idx, 2'b00} +: NIB];
    assign w_b = w_op ? r_y[{r_idx, 2'b00} +: NIB] : ~r_y[{r_idx, 2'b00} +: NIB];

    sub4_cla u_cla (
        .a    (w_a),
        .b    (w_b),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // The top nibble is still in flight on the last cycle, so the flags see
    // the freshly computed nibble spliced onto the lower twelve bits.
    assign w_z_final = {w_s, r_z[WIDTH-NIB-1:0]};

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_flags <= FLAGS_RESET;
        end else if (r_state == ST_IDLE) begin
            if (w_accept) begin
                r_x     <= X;
                r_y     <= Y;
                r_idx   <= '0;
                // Subtract seeds carry-in 1 (two's complement of Y).
                r_carry <= ~w_op_in;
            end
        end else if (r_state == ST_CALC) begin
            r_z[{r_idx, 2'b00} +: NIB] <= w_s;
            r_carry                    <= w_cout;
            r_idx                      <= r_idx + 1'b1;
            if (w_last) begin
                r_flags <= calc_flags(r_x, r_y, w_z_final, w_cout, w_op);
            end
        end
    end

`ifdef SUB16_ADDMODE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= 1'b0;
        end else if (w_accept) begin
            r_op <= op;
        end
    end
`endif

    assign Z        = r_z;
    assign Carry    = r_flags.carry;
    assign Parity   = r_flags.parity;
    assign Overflow = r_flags.overflow;
    assign Zero     = r_flags.zero;
    assign Sign     = r_flags.sign;

endmodule

// File: tb/tb_sub16_serial.sv
// tb/tb_sub16_serial.sv - self-checking bench for sub16_serial

module tb_sub16_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] X;
    logic [15:0] Y;
    logic        op_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Z;
    logic        Carry;
    logic        Parity;
    logic        Overflow;
    logic        Zero;
    logic        Sign;

    int n_checks = 0;
    int n_fail   = 0;

    sub16_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
`ifdef SUB16_ADDMODE_EN
        .op        (op_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z),
        .Carry     (Carry),
        .Parity    (Parity),
        .Overflow  (Overflow),
        .Zero      (Zero),
        .Sign      (Sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Flags packed as {C,P,O,Z,S}.
    task automatic model(input logic [15:0] x, input logic [15:0] y, input logic add,
                         output logic [15:0] z, output logic [4:0] f);
        int sx, sy, sr, ur;
        logic c, ov;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (add) begin
            ur = int'(x) + int'(y);
            sr = sx + sy;
            c  = (ur > 65535);
        end else begin
            ur = int'(x) - int'(y);
            sr = sx - sy;
            c  = (int'(x) < int'(y));
        end
        z  = 16'(ur);
        ov = (sr > 32767) || (sr < -32768);
        f  = {c, ($countones(z) % 2 == 0), ov, (z == 16'h0), z[15]};
    endtask

    function automatic logic [4:0] dut_flags();
        return {Carry, Parity, Overflow, Zero, Sign};
    endfunction

    // One full transaction. 'hold' cycles of back-pressure before out_ready.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic op,
                         input int hold, input string tag);
        logic [15:0] ez;
        logic [4:0]  ef;
        logic        add;
`ifdef SUB16_ADDMODE_EN
        add = op;
`else
        add = 1'b0;
`endif
        model(x, y, add, ez, ef);
        @(negedge clk);
        chk({tag, "/in_ready_idle"}, 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        X        = x;
        Y        = y;
        op_i     = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        X        = 16'($urandom);
        Y        = 16'($urandom);
        op_i     = 1'($urandom);
        // Counting the accepting edge as the first, out_valid appears after the fifth.
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            chk({tag, "/out_valid_timing"}, 16'(out_valid), 16'(e == 4));
            chk({tag, "/in_ready_busy"}, 16'(in_ready), 16'd0);
        end
        chk({tag, "/Z"}, Z, ez);
        chk({tag, "/flags"}, 16'(dut_flags()), 16'(ef));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            X = 16'($urandom);
            Y = 16'($urandom);
            chk({tag, "/hold_valid"}, 16'(out_valid), 16'd1);
            chk({tag, "/hold_in_ready"}, 16'(in_ready), 16'd0);
            chk({tag, "/hold_Z"}, Z, ez);
            chk({tag, "/hold_flags"}, 16'(dut_flags()), 16'(ef));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "/out_valid_drop"}, 16'(out_valid), 16'd0);
        chk({tag, "/in_ready_back"}, 16'(in_ready), 16'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        X         = 16'h0;
        Y         = 16'h0;
        op_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/in_ready", 16'(in_ready), 16'd1);
        chk("reset/out_valid", 16'(out_valid), 16'd0);
        chk("reset/Z", Z, 16'h0000);
        chk("reset/flags", 16'(dut_flags()), 16'(5'b01010));
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'h1234, 16'h0234, 1'b0, 0,  "basic");
        do_op(16'hA5A5, 16'hA5A5, 1'b0, 1,  "equal");
        do_op(16'h0000, 16'h0001, 1'b0, 0,  "wrap");
        do_op(16'h8000, 16'h0001, 1'b0, 0,  "ovf_neg");
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 10, "ovf_pos_bp");

        // Reset while in CALC aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        X        = 16'h4321;
        Y        = 16'h1111;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_calc/in_ready", 16'(in_ready), 16'd1);
        chk("rst_calc/out_valid", 16'(out_valid), 16'd0);
        chk("rst_calc/Z", Z, 16'h0000);
        chk("rst_calc/flags", 16'(dut_flags()), 16'(5'b01010));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            chk("rst_calc/no_valid", 16'(out_valid), 16'd0);
            chk("rst_calc/idle", 16'(in_ready), 16'd1);
        end

        do_op(16'hFFFF, 16'h8000, 1'b0, 2, "after_reset");

`ifdef SUB16_ADDMODE_EN
        do_op(16'hFFFF, 16'h0001, 1'b1, 0, "add_zero");
        do_op(16'h7FFF, 16'h0001, 1'b1, 0, "add_ovf");
`endif

        for (int r = 0; r < 24; r++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
